// File: rtl/div_ctrl.sv
// Iterative radix-2 restoring divider sequencer for DIV/DIVU in EX.
// Latency: WIDTH+1 cycles from start to valid (1 cycle for divide-by-zero).
// Backpressure: raises stall_div while accepting/iterating; results are held until the next completion.
module div_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             flush,
  output logic             stall_div,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd;       // dividend shifting out, quotient bits shifting in
  logic [WIDTH-1:0] rem;       // partial remainder
  logic [WIDTH-1:0] dsr;       // divisor magnitude
  logic             neg_q;
  logic             neg_r;

  logic             accept;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   trial;
  logic             qbit;
  logic [WIDTH-1:0] rem_nxt, dvd_nxt;

  // An op is taken only from IDLE; flush outranks start.
  assign accept = (state == IDLE) && start && !flush;

  // Magnitudes are taken only for signed ops; the most negative value maps to itself,
  // which is still the correct unsigned magnitude.
  assign a_abs = (signed_op && opa[WIDTH-1]) ? (~opa + 1'b1) : opa;
  assign b_abs = (signed_op && opb[WIDTH-1]) ? (~opb + 1'b1) : opb;

  // One restoring step: the shifted remainder needs WIDTH+1 bits before the compare.
  assign trial   = {rem, dvd[WIDTH-1]} - {1'b0, dsr};
  assign qbit    = !trial[WIDTH];
  assign rem_nxt = qbit ? trial[WIDTH-1:0] : {rem[WIDTH-2:0], dvd[WIDTH-1]};
  assign dvd_nxt = {dvd[WIDTH-2:0], qbit};

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic; flush returns to IDLE from any state.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (opb == '0) ? DONE : RUN;
      RUN:     if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // Outputs decoded from state; stall is suppressed while in reset.
  always_comb begin
    stall_div = resetn && (accept || (state == RUN));
    busy      = (state != IDLE);
    valid     = (state == DONE) && !flush;
  end

  // Datapath: operand capture, iteration, and result registers (updated only on entry to DONE).
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt       <= '0;
      dvd       <= '0;
      rem       <= '0;
      dsr       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else if (!flush) begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (opb == '0) begin
              quotient  <= '1;
              remainder <= opa;
              div_zero  <= 1'b1;
            end else begin
              cnt   <= CW'(WIDTH - 1);
              dvd   <= a_abs;
              dsr   <= b_abs;
              rem   <= '0;
              neg_q <= signed_op && (opa[WIDTH-1] ^ opb[WIDTH-1]);
              neg_r <= signed_op && opa[WIDTH-1];
            end
          end
        end
        RUN: begin
          dvd <= dvd_nxt;
          rem <= rem_nxt;
          if (cnt == '0) begin
            quotient  <= neg_q ? (~dvd_nxt + 1'b1) : dvd_nxt;
            remainder <= neg_r ? (~rem_nxt + 1'b1) : rem_nxt;
            div_zero  <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: directed corner cases plus random ops vs. an arithmetic model.
// Checks cycle-level stall/valid timing, results, flush and reset behaviour.
// Inputs are driven 1ns after the rising edge, outputs sampled on the falling edge.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic        signed_op;
  logic [31:0] opa, opb;
  logic        flush;
  logic        stall_div, busy, valid, div_zero;
  logic [31:0] quotient, remainder;

  int checks = 0;
  int errors = 0;

  div_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .resetn(resetn), .start(start), .signed_op(signed_op),
    .opa(opa), .opb(opb), .flush(flush), .stall_div(stall_div), .busy(busy),
    .valid(valid), .quotient(quotient), .remainder(remainder), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Reference: plain arithmetic with the divide-by-zero and overflow rules applied first.
  function automatic void model(input bit s, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r, output bit dz);
    int sa, sb;
    dz = 1'b0;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; dz = 1'b1;
    end else if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000; r = 32'd0;
      end else begin
        sa = int'(a); sb = int'(b);
        q = 32'(sa / sb);
        r = 32'(sa % sb);
      end
    end else begin
      q = a / b; r = a % b;
    end
  endfunction

  // Issues one op with start held through DONE, scrambles operands after cycle 0,
  // and checks stall length, valid timing/count and results.
  task automatic do_op(input bit s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eq, er;
    bit          edz;
    int          stall_n, vcyc, vcount, exp_lat;
    model(s, a, b, eq, er, edz);
    exp_lat = (b == 32'd0) ? 1 : 33;
    stall_n = 0; vcyc = -1; vcount = 0;
    @(posedge clk); #1;
    start = 1'b1; signed_op = s; opa = a; opb = b;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (stall_div) stall_n++;
      if (valid) begin
        vcount++;
        if (vcyc < 0) begin
          vcyc = c;
          check("quotient", quotient, eq);
          check("remainder", remainder, er);
          check("div_zero", 32'(div_zero), 32'(edz));
        end
      end
      @(posedge clk); #1;
      opa = $urandom; opb = $urandom;
      if (vcyc >= 0) start = 1'b0;
    end
    start = 1'b0;
    check("stall_cycles", 32'(stall_n), 32'(exp_lat));
    check("valid_cycle", 32'(vcyc), 32'(exp_lat));
    check("valid_count", 32'(vcount), 32'd1);
    check("q_held", quotient, eq);
  endtask

  logic [31:0] prev_q, prev_r;

  initial begin
    resetn = 1'b0; start = 1'b1; signed_op = 1'b0; opa = 32'd1; opb = 32'd1; flush = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_stall", 32'(stall_div), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_q", quotient, 32'd0);
    check("rst_r", remainder, 32'd0);
    check("rst_dz", 32'(div_zero), 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1; start = 1'b0;

    do_op(1'b0, 32'd100, 32'd7);
    do_op(1'b1, 32'hFFFF_FFF9, 32'd2);
    do_op(1'b1, 32'd7, 32'hFFFF_FFFE);
    do_op(1'b0, 32'd5, 32'd0);
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);

    // Flush in RUN cycle 10: op abandoned, results hold.
    prev_q = quotient; prev_r = remainder;
    @(posedge clk); #1;
    start = 1'b1; signed_op = 1'b0; opa = 32'd100; opb = 32'd7;
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    check("flush_valid_c10", 32'(valid), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    @(negedge clk);
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_valid", 32'(valid), 32'd0);
    check("flush_stall", 32'(stall_div), 32'd0);
    check("flush_q", quotient, prev_q);
    check("flush_r", remainder, prev_r);
    do_op(1'b0, 32'd9, 32'd3);

    // Flush outranks start in IDLE.
    @(posedge clk); #1;
    start = 1'b1; flush = 1'b1; opa = 32'd50; opb = 32'd5;
    @(negedge clk);
    check("idle_flush_stall", 32'(stall_div), 32'd0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("idle_flush_busy", 32'(busy), 32'd0);

    // Random ops, with occasional zero divisor and signed overflow.
    for (int i = 0; i < 24; i++) begin
      logic [31:0] a, b;
      bit s;
      s = 1'($urandom);
      a = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      do_op(s, a, b);
    end

    // Reset mid-RUN abandons the op and clears outputs.
    @(posedge clk); #1;
    start = 1'b1; signed_op = 1'b0; opa = 32'd100; opb = 32'd7;
    repeat (5) @(posedge clk);
    #1 resetn = 1'b0; start = 1'b0;
    @(negedge clk);
    check("rstrun_stall", 32'(stall_div), 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    check("rstrun_busy", 32'(busy), 32'd0);
    check("rstrun_valid", 32'(valid), 32'd0);
    check("rstrun_q", quotient, 32'd0);
    check("rstrun_r", remainder, 32'd0);
    check("rstrun_dz", 32'(div_zero), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
